// File: rtl/dso_cal_pkg.sv
// Shared types and constants for the DSO offset calibration path.
// Latency: none (declarations only); backpressure: not applicable.
package dso_cal_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACCUM   = 2'd2,
        COMPUTE = 2'd3
    } cal_state_t;

    localparam logic [7:0] MIDSCALE = 8'h80;

endpackage

// File: rtl/offset_clamp.sv
// Rounds the accumulated sum to a mean, forms MIDSCALE - mean and clamps it to +/-MAX_OFF.
// Latency: combinational; backpressure: none.
module offset_clamp
    import dso_cal_pkg::*;
#(
    parameter int LOG2_N  = 8,
    parameter int MAX_OFF = 64
) (
    input  logic [8+LOG2_N-1:0] acc_i,
    output logic [7:0]          off_next_o,
    output logic                err_next_o
);

    localparam int AW = 8 + LOG2_N;
    localparam logic [AW:0] HALF = {{AW{1'b0}}, 1'b1} << (LOG2_N - 1);
    localparam logic signed [9:0] MAX_S = 10'(MAX_OFF);
    localparam logic signed [9:0] MIN_S = -MAX_S;

    logic [AW:0]          sum;
    logic                 sum_top_unused;
    logic [LOG2_N-1:0]    frac_unused;
    logic [7:0]           mean;
    logic signed [9:0]    ideal;

    // One extra bit keeps the rounding add from wrapping at full-scale input.
    assign sum = {1'b0, acc_i} + HALF;
    assign {sum_top_unused, mean, frac_unused} = sum;
    assign ideal = $signed({2'b00, MIDSCALE}) - $signed({2'b00, mean});

    always_comb begin
        off_next_o = ideal[7:0];
        err_next_o = 1'b0;
        if (ideal > MAX_S) begin
            off_next_o = MAX_S[7:0];
            err_next_o = 1'b1;
        end else if (ideal < MIN_S) begin
            off_next_o = MIN_S[7:0];
            err_next_o = 1'b1;
        end
    end

endmodule

// File: rtl/offset_calibrator.sv
// Averages 2^LOG2_N grounded ADC samples and holds the offset that recentres them at midscale.
// Latency: cal_done one edge after the last sample is taken; backpressure: none, samples gated by smpl_vld.
module offset_calibrator
    import dso_cal_pkg::*;
#(
    parameter int LOG2_N       = 8,
    parameter int SETTLE_SMPLS = 4,
    parameter int MAX_OFF      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cal_start,
    input  logic       cal_abort,
    input  logic       smpl_vld,
    input  logic [7:0] raw,
    output logic [7:0] off,
    output logic       cal_busy,
    output logic       cal_done,
    output logic       cal_err
);

    localparam int AW = 8 + LOG2_N;
    localparam logic [7:0] SETTLE_LAST = (SETTLE_SMPLS == 0) ? 8'd0 : 8'(SETTLE_SMPLS - 1);
    localparam logic [LOG2_N-1:0] SMPL_LAST = '1;

    cal_state_t        state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [7:0]        settle_cnt_q, settle_cnt_d;
    logic [LOG2_N-1:0] smpl_cnt_q, smpl_cnt_d;
    logic [7:0]        off_q, off_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [7:0]        clamp_off;
    logic              clamp_err;

    offset_clamp #(
        .LOG2_N  (LOG2_N),
        .MAX_OFF (MAX_OFF)
    ) u_clamp (
        .acc_i      (acc_q),
        .off_next_o (clamp_off),
        .err_next_o (clamp_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cal_start && !cal_abort) begin
                    state_d = (SETTLE_SMPLS == 0) ? ACCUM : SETTLE;
                end
            end
            SETTLE: begin
                if (cal_abort) begin
                    state_d = IDLE;
                end else if (smpl_vld && settle_cnt_q == SETTLE_LAST) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (cal_abort) begin
                    state_d = IDLE;
                end else if (smpl_vld && smpl_cnt_q == SMPL_LAST) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d        = acc_q;
        settle_cnt_d = settle_cnt_q;
        smpl_cnt_d   = smpl_cnt_q;
        off_d        = off_q;
        err_d        = err_q;
        done_d       = 1'b0;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (cal_start && !cal_abort) begin
                    acc_d        = '0;
                    settle_cnt_d = '0;
                    smpl_cnt_d   = '0;
                    err_d        = 1'b0;
                end
            end
            SETTLE: begin
                if (smpl_vld && !cal_abort) begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ACCUM: begin
                if (smpl_vld && !cal_abort) begin
                    acc_d      = acc_q + AW'(raw);
                    smpl_cnt_d = smpl_cnt_q + LOG2_N'(1);
                end
            end
            COMPUTE: begin
                // An abort landing on the compute cycle still discards the result.
                if (!cal_abort) begin
                    off_d  = clamp_off;
                    err_d  = clamp_err;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            settle_cnt_q <= '0;
            smpl_cnt_q   <= '0;
            off_q        <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            settle_cnt_q <= settle_cnt_d;
            smpl_cnt_q   <= smpl_cnt_d;
            off_q        <= off_d;
            err_q        <= err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign off      = off_q;
    assign cal_busy = busy_q;
    assign cal_done = done_q;
    assign cal_err  = err_q;

endmodule
